vai_tx_rr_arbiter: RTL

- Shares one upstream CCI-P request channel among NUM_SUB_AFUS sub-AFU requesters, using round-robin arbitration.
- Stamps each granted request with the requester's VM id in the top bits of mdata. The Rx-side audit demux later uses these bits to steer responses back.
- Tracks in-flight requests per VM and enforces a per-VM outstanding quota.
- Sits between the per-sub-AFU Tx ports and the single upstream Tx port.

---
 rtl/vai_tx_rr_arbiter_if.sv | 27 ++
 rtl/vai_tx_rr_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/vai_tx_rr_arbiter_if.sv
// vai_tx_rr_arbiter_if: per-requester Tx request bus plus the shared upstream Tx and
// response-return signals seen by the round-robin arbiter.
interface vai_tx_rr_arbiter_if #(
  parameter int NUM_SUB_AFUS  = 8,
  parameter int PAYLOAD_WIDTH = 512
);
  logic [NUM_SUB_AFUS-1:0]                    req_valid;
  logic [NUM_SUB_AFUS-1:0][15:0]              req_mdata;
  logic [NUM_SUB_AFUS-1:0][PAYLOAD_WIDTH-1:0] req_payload;
  logic [NUM_SUB_AFUS-1:0]                    req_ready;
  logic                                       up_almfull;
  logic                                       up_valid;
  logic [15:0]                                up_mdata;
  logic [PAYLOAD_WIDTH-1:0]                   up_payload;
  logic                                       rsp_valid;
  logic [15:0]                                rsp_mdata;

  modport slave (
    input  req_valid, req_mdata, req_payload, up_almfull, rsp_valid, rsp_mdata,
    output req_ready, up_valid, up_mdata, up_payload
  );

  modport master (
    output req_valid, req_mdata, req_payload, up_almfull, rsp_valid, rsp_mdata,
    input  req_ready, up_valid, up_mdata, up_payload
  );
endinterface

// File: rtl/vai_tx_rr_arbiter.sv
// vai_tx_rr_arbiter: round-robin share of one upstream CCI-P Tx channel among sub-AFUs,
// stamping the VM id into the top mdata bits and enforcing a per-VM outstanding quota.
module vai_tx_rr_arbiter #(
  parameter  int NUM_SUB_AFUS    = 8,
  parameter  int PAYLOAD_WIDTH   = 512,
  parameter  int MAX_OUTSTANDING = 64,
  localparam int VMID_WIDTH      = $clog2(NUM_SUB_AFUS),
  localparam int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  vai_tx_rr_arbiter_if.slave      bus,
  input  logic [NUM_SUB_AFUS-1:0] vm_enable,
  output logic [NUM_SUB_AFUS-1:0] quota_block,
  output logic                    err_underflow
);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [VMID_WIDTH:0]   NUM_EXT   = (VMID_WIDTH+1)'(NUM_SUB_AFUS);
  localparam logic [VMID_WIDTH-1:0] LAST_IDX  = VMID_WIDTH'(NUM_SUB_AFUS - 1);
  localparam int                    LOW_WIDTH = 16 - VMID_WIDTH;

  logic [VMID_WIDTH-1:0]                      rr_ptr_q, rr_ptr_d;
  logic [NUM_SUB_AFUS-1:0][CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic [NUM_SUB_AFUS-1:0]                    quota_q, eligible, elig_rot, gnt_oh, rsp_hit;
  logic [2*NUM_SUB_AFUS-1:0]                  elig_dbl;
  logic                                       gnt_valid, up_valid_q, err_q, err_d;
  logic [VMID_WIDTH-1:0]                      gnt_off, gnt_idx, rsp_vm;
  logic [VMID_WIDTH:0]                        gnt_sum;
  logic [15:0]                                up_mdata_q, up_mdata_d;
  logic [PAYLOAD_WIDTH-1:0]                   up_payload_q, up_payload_d;

  // Reset and almfull mask every requester so req_ready is zero in both cases.
  always_comb begin
    for (int i = 0; i < NUM_SUB_AFUS; i++) begin
      eligible[i] = reset_n & ~bus.up_almfull & bus.req_valid[i] & vm_enable[i] &
                    (cnt_q[i] < CNT_MAX);
    end
  end

  // Rotate so bit 0 is rr_ptr; the lowest set bit is then the round-robin winner.
  assign elig_dbl = {eligible, eligible} >> rr_ptr_q;
  assign elig_rot = elig_dbl[NUM_SUB_AFUS-1:0];

  always_comb begin
    gnt_valid = 1'b0;
    gnt_off   = '0;
    for (int o = NUM_SUB_AFUS - 1; o >= 0; o--) begin
      if (elig_rot[o]) begin
        gnt_valid = 1'b1;
        gnt_off   = VMID_WIDTH'(o);
      end
    end
  end

  assign gnt_sum  = {1'b0, rr_ptr_q} + {1'b0, gnt_off};
  assign gnt_idx  = VMID_WIDTH'((gnt_sum >= NUM_EXT) ? gnt_sum - NUM_EXT : gnt_sum);
  assign gnt_oh   = {{(NUM_SUB_AFUS-1){1'b0}}, gnt_valid} << gnt_idx;
  assign rr_ptr_d = !gnt_valid ? rr_ptr_q : (gnt_idx == LAST_IDX) ? '0 : gnt_idx + VMID_WIDTH'(1);

  assign up_mdata_d   = gnt_valid ? {gnt_idx, bus.req_mdata[gnt_idx][LOW_WIDTH-1:0]} : '0;
  assign up_payload_d = gnt_valid ? bus.req_payload[gnt_idx] : '0;

  // Out-of-range VM ids in a response never match any counter.
  assign rsp_vm = bus.rsp_mdata[15 -: VMID_WIDTH];

  always_comb begin
    for (int i = 0; i < NUM_SUB_AFUS; i++) begin
      rsp_hit[i] = bus.rsp_valid & (rsp_vm == VMID_WIDTH'(i));
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    for (int i = 0; i < NUM_SUB_AFUS; i++) begin
      if (rsp_hit[i] && cnt_q[i] == '0) err_d = 1'b1;
      cnt_d[i] = (gnt_oh[i] && !rsp_hit[i])                    ? cnt_q[i] + CNT_WIDTH'(1) :
                 (rsp_hit[i] && !gnt_oh[i] && cnt_q[i] != '0) ? cnt_q[i] - CNT_WIDTH'(1) :
                                                                  cnt_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      quota_q      <= '0;
      err_q        <= 1'b0;
      up_valid_q   <= 1'b0;
      up_mdata_q   <= '0;
      up_payload_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      up_valid_q   <= gnt_valid;
      up_mdata_q   <= up_mdata_d;
      up_payload_q <= up_payload_d;
      for (int i = 0; i < NUM_SUB_AFUS; i++) quota_q[i] <= (cnt_d[i] == CNT_MAX);
    end
  end

  assign bus.req_ready  = gnt_oh;
  assign bus.up_valid   = up_valid_q;
  assign bus.up_mdata   = up_mdata_q;
  assign bus.up_payload = up_payload_q;
  assign quota_block    = quota_q;
  assign err_underflow  = err_q;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(gnt_oh));
  a_grant_valid:   assert property (@(posedge clk) disable iff (!reset_n)
                                    (gnt_oh & ~bus.req_valid) == '0);
endmodule
